// File: rtl/wb_pipe_reg.sv
// ---------------------------------------------------------------------------
// wb_pipe_reg
//   Memory-to-Writeback pipeline register for the pipelined Y-86 core.
//   It captures the M-stage results into W one cycle later. It also supports
//   stall (hold), bubble (load a NOP) and a valid bit. A sticky HALTED state
//   freezes W once a valid non-AOK status has been captured. Three saturating
//   counters (retire, stall, bubble) are provided for performance debug.
//
// Handshake: this stage uses no valid/ready handshake. W_stall and W_bubble
//   are level controls sampled on each rising edge. W_stall has priority over
//   W_bubble. In HALTED both controls are ignored.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   m_stat, M_icode,      M-stage instruction fields
//   M_valE, m_valM,
//   M_dstE, M_dstM
//   M_valid               M stage holds a real instruction
//   W_stall, W_bubble     pipeline control for this register
//   W_*                   registered W-stage fields
//   W_valid               W holds a real instruction
//   W_halted              sticky halt flag; reflects the FSM state
//   retire_cnt,           saturating performance counters
//   stall_cnt,
//   bubble_cnt
// ---------------------------------------------------------------------------
module wb_pipe_reg #(
    parameter int DATA_W    = 64,
    parameter int ICODE_W   = 4,
    parameter int REG_W     = 4,
    parameter int STAT_W    = 3,
    parameter int CNT_W     = 32,
    parameter int STAT_AOK  = 1,
    parameter int ICODE_NOP = 1,
    parameter int REG_NONE  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [DATA_W-1:0]  M_valE,
    input  logic [DATA_W-1:0]  m_valM,
    input  logic [REG_W-1:0]   M_dstE,
    input  logic [REG_W-1:0]   M_dstM,
    input  logic               M_valid,
    input  logic               W_stall,
    input  logic               W_bubble,
    output logic [STAT_W-1:0]  W_stat,
    output logic [ICODE_W-1:0] W_icode,
    output logic [DATA_W-1:0]  W_valE,
    output logic [DATA_W-1:0]  W_valM,
    output logic [REG_W-1:0]   W_dstE,
    output logic [REG_W-1:0]   W_dstM,
    output logic               W_valid,
    output logic               W_halted,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [STAT_W-1:0]  LP_AOK  = STAT_W'(STAT_AOK);
    localparam logic [ICODE_W-1:0] LP_NOP  = ICODE_W'(ICODE_NOP);
    localparam logic [REG_W-1:0]   LP_NONE = REG_W'(REG_NONE);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    logic [STAT_W-1:0]  r_stat;
    logic [ICODE_W-1:0] r_icode;
    logic [DATA_W-1:0]  r_valE;
    logic [DATA_W-1:0]  r_valM;
    logic [REG_W-1:0]   r_dstE;
    logic [REG_W-1:0]   r_dstM;
    logic               r_valid;
    logic [CNT_W-1:0]   r_retire_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_bubble_cnt;

    // Saturating increments: once a counter is all-ones, it stays there.
    logic [CNT_W-1:0] w_retire_inc;
    logic [CNT_W-1:0] w_stall_inc;
    logic [CNT_W-1:0] w_bubble_inc;
    logic             w_m_aok;

    always_comb begin
        w_retire_inc = (&r_retire_cnt) ? r_retire_cnt : r_retire_cnt + 1'b1;
        w_stall_inc  = (&r_stall_cnt)  ? r_stall_cnt  : r_stall_cnt  + 1'b1;
        w_bubble_inc = (&r_bubble_cnt) ? r_bubble_cnt : r_bubble_cnt + 1'b1;
        w_m_aok      = (m_stat == LP_AOK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_stat       <= LP_AOK;
            r_icode      <= LP_NOP;
            r_valE       <= '0;
            r_valM       <= '0;
            r_dstE       <= LP_NONE;
            r_dstM       <= LP_NONE;
            r_valid      <= 1'b0;
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (W_stall) begin
                        // Hold every field. The M inputs are not read, so X on them cannot leak into W.
                        r_stall_cnt <= w_stall_inc;
                    end else if (W_bubble) begin
                        r_stat       <= LP_AOK;
                        r_icode      <= LP_NOP;
                        r_valE       <= '0;
                        r_valM       <= '0;
                        r_dstE       <= LP_NONE;
                        r_dstM       <= LP_NONE;
                        r_valid      <= 1'b0;
                        r_bubble_cnt <= w_bubble_inc;
                    end else begin
                        r_stat  <= m_stat;
                        r_icode <= M_icode;
                        r_valE  <= M_valE;
                        r_valM  <= m_valM;
                        r_dstE  <= M_dstE;
                        r_dstM  <= M_dstM;
                        r_valid <= M_valid;
                        if (M_valid) begin
                            if (w_m_aok) begin
                                r_retire_cnt <= w_retire_inc;
                            end else begin
                                // The faulting instruction is captured on the same edge that halts W.
                                r_state <= ST_HALTED;
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    // Frozen; only reset leaves this state.
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign W_stat     = r_stat;
    assign W_icode    = r_icode;
    assign W_valE     = r_valE;
    assign W_valM     = r_valM;
    assign W_dstE     = r_dstE;
    assign W_dstM     = r_dstM;
    assign W_valid    = r_valid;
    assign W_halted   = (r_state == ST_HALTED);
    assign retire_cnt = r_retire_cnt;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_wb_pipe_reg
//   Directed bench for wb_pipe_reg. u_dut uses the default parameters.
//   u_sat uses CNT_W=3 so that counter saturation is reachable. Both
//   instances receive the same inputs.
// ---------------------------------------------------------------------------
module tb_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  m_stat;
    logic [3:0]  M_icode;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        M_valid;
    logic        W_stall;
    logic        W_bubble;

    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic        W_valid;
    logic        W_halted;
    logic [31:0] retire_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;

    logic [2:0]  s_stat;
    logic [3:0]  s_icode;
    logic [63:0] s_valE;
    logic [63:0] s_valM;
    logic [3:0]  s_dstE;
    logic [3:0]  s_dstM;
    logic        s_valid;
    logic        s_halted;
    logic [2:0]  s_retire_cnt;
    logic [2:0]  s_stall_cnt;
    logic [2:0]  s_bubble_cnt;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    wb_pipe_reg u_dut (
        .clk(clk), .reset(reset),
        .m_stat(m_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valid(M_valid),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valid(W_valid), .W_halted(W_halted),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    wb_pipe_reg #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(reset),
        .m_stat(m_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valid(M_valid),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .W_stat(s_stat), .W_icode(s_icode), .W_valE(s_valE), .W_valM(s_valM),
        .W_dstE(s_dstE), .W_dstM(s_dstM), .W_valid(s_valid), .W_halted(s_halted),
        .retire_cnt(s_retire_cnt), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    // ---------------- driver tasks ----------------
    // Advance one rising edge. Outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic v, input logic [2:0] st, input logic [3:0] ic,
                           input logic [63:0] ve, input logic [63:0] vm,
                           input logic [3:0] de, input logic [3:0] dm);
        M_valid = v;
        m_stat  = st;
        M_icode = ic;
        M_valE  = ve;
        m_valM  = vm;
        M_dstE  = de;
        M_dstM  = dm;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Check all W fields, the valid bit and the halt flag of u_dut in one call.
    task automatic check_w(input string tag, input logic [2:0] st, input logic [3:0] ic,
                           input logic [63:0] ve, input logic [63:0] vm,
                           input logic [3:0] de, input logic [3:0] dm,
                           input logic v, input logic h);
        check({tag, ".stat"},   64'(W_stat),   64'(st));
        check({tag, ".icode"},  64'(W_icode),  64'(ic));
        check({tag, ".valE"},   W_valE,        ve);
        check({tag, ".valM"},   W_valM,        vm);
        check({tag, ".dstE"},   64'(W_dstE),   64'(de));
        check({tag, ".dstM"},   64'(W_dstM),   64'(dm));
        check({tag, ".valid"},  64'(W_valid),  64'(v));
        check({tag, ".halted"}, 64'(W_halted), 64'(h));
    endtask

    task automatic check_cnt(input string tag, input int r, input int s, input int b);
        check({tag, ".retire"}, 64'(retire_cnt), 64'(r));
        check({tag, ".stall"},  64'(stall_cnt),  64'(s));
        check({tag, ".bubble"}, 64'(bubble_cnt), 64'(b));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        drive_m(1'b0, 3'd1, 4'd0, 64'd0, 64'd0, 4'd0, 4'd0);
        tick(); tick();
        reset = 1'b0;
        check_w("reset", 3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        check_cnt("reset", 0, 0, 0);

        // Basic load; the data appears in W one edge later.
        drive_m(1'b1, 3'd1, 4'd6, 64'h1234, 64'hDEAD, 4'd3, 4'hF);
        tick();
        check_w("load1", 3'd1, 4'd6, 64'h1234, 64'hDEAD, 4'd3, 4'hF, 1'b1, 1'b0);
        check_cnt("load1", 1, 0, 0);

        // Load A, then stall 3 cycles while the M inputs change.
        drive_m(1'b1, 3'd1, 4'd2, 64'hAAAA, 64'hBBBB, 4'd4, 4'd5);
        tick();
        W_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_m(1'b1, 3'd1, 4'(7 + i), 64'(100 + i), 64'(200 + i), 4'(i), 4'(i + 1));
            if (i == 1) m_valM = 'x;
            tick();
        end
        check_w("stall", 3'd1, 4'd2, 64'hAAAA, 64'hBBBB, 4'd4, 4'd5, 1'b1, 1'b0);
        check_cnt("stall", 2, 3, 0);

        // Bubble with valid AOK inputs present.
        W_stall = 1'b0; W_bubble = 1'b1;
        drive_m(1'b1, 3'd1, 4'd6, 64'h77, 64'h88, 4'd1, 4'd2);
        tick();
        check_w("bubble", 3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        check_cnt("bubble", 2, 3, 1);

        // Stall has priority over a simultaneous bubble.
        W_stall = 1'b1;
        drive_m(1'b1, 3'd1, 4'd5, 64'h11, 64'h22, 4'd1, 4'd2);
        tick();
        check_w("stall_bub", 3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        check_cnt("stall_bub", 2, 4, 1);

        // Invalid M: the fields are captured, W_valid is 0 and no counter moves.
        W_stall = 1'b0; W_bubble = 1'b0;
        drive_m(1'b0, 3'd1, 4'd7, 64'h55, 64'h66, 4'd2, 4'd3);
        tick();
        check_w("invalid", 3'd1, 4'd7, 64'h55, 64'h66, 4'd2, 4'd3, 1'b0, 1'b0);
        check_cnt("invalid", 2, 4, 1);

        // Invalid M with a non-AOK status must not halt.
        drive_m(1'b0, 3'd2, 4'd0, 64'h5, 64'h6, 4'd2, 4'd3);
        tick();
        check("inv_hlt.halted", 64'(W_halted), 64'd0);

        // HLT retires: W_halted rises on the same edge.
        drive_m(1'b1, 3'd2, 4'd0, 64'h99, 64'h77, 4'hF, 4'hF);
        tick();
        check_w("halt", 3'd2, 4'd0, 64'h99, 64'h77, 4'hF, 4'hF, 1'b1, 1'b1);
        check_cnt("halt", 2, 4, 1);

        // Frozen for 5 cycles: load, stall, bubble, load, stall+bubble.
        for (int i = 0; i < 5; i++) begin
            W_stall  = (i == 1 || i == 4);
            W_bubble = (i == 2 || i == 4);
            drive_m(1'b1, 3'd1, 4'd3, 64'(300 + i), 64'(400 + i), 4'd1, 4'd1);
            if (i == 3) M_valE = 'x;
            tick();
        end
        check_w("frozen", 3'd2, 4'd0, 64'h99, 64'h77, 4'hF, 4'hF, 1'b1, 1'b1);
        check_cnt("frozen", 2, 4, 1);

        // Reset from HALTED, asserted together with a stall and a valid load.
        reset = 1'b1; W_stall = 1'b1; W_bubble = 1'b0;
        drive_m(1'b1, 3'd1, 4'd6, 64'hCAFE, 64'hBEEF, 4'd1, 4'd2);
        tick();
        check_w("rst_stall", 3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        check_cnt("rst_stall", 0, 0, 0);

        // Reset together with a plain valid load.
        W_stall = 1'b0;
        tick();
        check_w("rst_load", 3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        check_cnt("rst_load", 0, 0, 0);

        // The first edge after reset deasserts performs a normal load.
        reset = 1'b0;
        drive_m(1'b1, 3'd1, 4'd3, 64'h42, 64'h43, 4'd1, 4'd2);
        tick();
        check_w("post_rst", 3'd1, 4'd3, 64'h42, 64'h43, 4'd1, 4'd2, 1'b1, 1'b0);
        check_cnt("post_rst", 1, 0, 0);
        check("sat.start", 64'(s_retire_cnt), 64'd1);

        // 9 more valid AOK loads. The 3-bit counter saturates at 7.
        for (int i = 0; i < 9; i++) begin
            drive_m(1'b1, 3'd1, 4'd6, 64'(i), 64'(i + 1), 4'd0, 4'd1);
            tick();
            if (i == 4) check("sat.below", 64'(s_retire_cnt), 64'd6);
            if (i == 5) check("sat.reach", 64'(s_retire_cnt), 64'd7);
        end
        check("sat.hold", 64'(s_retire_cnt), 64'd7);
        check("sat.wide", 64'(retire_cnt), 64'd10);
        check("sat.valE", s_valE, 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg.md
Name: wb_pipe_reg

Overview:
Parametrised Memory-to-Writeback pipeline register for the pipelined Y-86 core. Next generation of the fixed 64-bit W stage register. Adds:
- configurable widths
- synchronous reset to a NOP bubble
- bubble injection
- a valid bit
- a sticky halt state that freezes W once a non-AOK status retires
- saturating retire, stall and bubble counters for performance debug

Parameters:
DATA_W, 64, width of valE/valM
ICODE_W, 4, instruction code width
REG_W, 4, register ID width
STAT_W, 3, status code width
CNT_W, 32, width of each performance counter
STAT_AOK, 1, status code meaning normal operation
ICODE_NOP, 1, icode loaded on reset/bubble
REG_NONE, 15, register ID meaning "no destination"

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
m_stat  in  STAT_W  status from memory stage
M_icode  in  ICODE_W  icode from M register
M_valE  in  DATA_W  ALU result from M register
m_valM  in  DATA_W  memory read data
M_dstE  in  REG_W  E destination register ID
M_dstM  in  REG_W  M destination register ID
M_valid  in  1  M stage holds a real instruction
W_stall  in  1  hold W contents this cycle
W_bubble  in  1  load NOP bubble this cycle
W_stat  out  STAT_W  registered status
W_icode  out  ICODE_W  registered icode
W_valE  out  DATA_W  registered valE
W_valM  out  DATA_W  registered valM
W_dstE  out  REG_W  registered dstE
W_dstM  out  REG_W  registered dstM
W_valid  out  1  W holds a real instruction
W_halted  out  1  sticky halt flag; W frozen
retire_cnt  out  CNT_W  valid AOK instructions loaded into W
stall_cnt  out  CNT_W  cycles W held by W_stall
bubble_cnt  out  CNT_W  bubbles loaded into W

Behaviour:
- All outputs are registers, updated only on posedge clk. Data latency M→W is one cycle; no combinational path from inputs to outputs.
- Reset (sync, active-high, highest priority, any state including HALTED):
  - W_stat=STAT_AOK, W_icode=ICODE_NOP, W_valE=W_valM=0
  - W_dstE=W_dstM=REG_NONE, W_valid=0, W_halted=0
  - all counters 0; state→RUN
- State machine, two states, RUN and HALTED (W_halted=1 iff HALTED).
- RUN, per-edge action priority:
  1. W_stall=1: hold all W fields; stall_cnt+1. Stall overrides a simultaneous W_bubble.
  2. W_bubble=1: load bubble (same field values as reset except counters and state); bubble_cnt+1.
  3. Otherwise load: all W fields ← M/m inputs; W_valid←M_valid.
     - If M_valid=1 and m_stat==STAT_AOK: retire_cnt+1.
     - If M_valid=1 and m_stat!=STAT_AOK: state→HALTED. W_halted rises on the same edge that captures the faulting instruction.
     - If M_valid=0: fields captured but W_valid=0; no counter changes.
- HALTED: all W fields, W_valid and all counters hold regardless of W_stall, W_bubble or M inputs. Exit only via reset.
- Counters saturate at all-ones and never wrap.
- Reset asserted together with stall/bubble/load: reset wins.
- Reset deasserted: the first edge without reset performs a normal RUN action.
- X on inputs while stalled or HALTED must not propagate to outputs.

Test Plan:
- Reset then load M_valid=1, m_stat=1, M_icode=6, M_valE=0x1234, m_valM=0xDEAD, dstE=3, dstM=0xF → next edge W fields match, W_valid=1, retire_cnt=1.
- Load instruction A, then assert W_stall 3 cycles while M inputs change each cycle → W fields stay A, stall_cnt=3, retire_cnt unchanged.
- W_bubble=1 with valid AOK M inputs → W_icode=1, dstE=dstM=0xF, W_valid=0, bubble_cnt=1. Then W_stall=1 and W_bubble=1 together → hold, stall_cnt+1, bubble_cnt unchanged.
- Load M_valid=1, m_stat=2 (HLT), M_icode=0 → W_halted=1 same edge. Next 5 cycles of new AOK inputs, stalls and bubbles → outputs and counters frozen. Then reset → reset values, W_halted=0.
- CNT_W=3, 9 consecutive valid AOK loads → retire_cnt reaches 7 and stays 7.
- Reset asserted simultaneously with valid load and with W_stall → reset values only. First cycle after deassert loads normally.
